// File: rtl/stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : stream_feeder
// Description : Upstream stage for a WIDTH-parameterised datapath consumer.
//               Accepts a valid/ready stream into a small FIFO and presents
//               each word downstream as a single-cycle enable_o strobe with a
//               registered data_o that holds between strobes. Supports a
//               downstream stall and a synchronous flush, and reports the
//               number of stored entries.
// Ports       : clk_i      - clock, all logic on the rising edge
//               rst_ni     - asynchronous active-low reset
//               clear_i    - synchronous flush, overrides every other input
//               s_valid_i  - upstream word valid
//               s_ready_o  - feeder can accept a word this cycle
//               s_data_i   - upstream word
//               stall_i    - downstream hold; no strobe issued while high
//               enable_o   - one-cycle strobe, data_o valid this cycle
//               data_o     - output word, registered, held between strobes
//               level_o    - entries stored (0..DEPTH), excludes data_o word
//               state_o    - 0 IDLE, 1 STREAM, 2 HOLD
// Revision    : 1.0 - initial release
// ============================================================================
module stream_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [WIDTH-1:0]         s_data_i,
  input  logic                     stall_i,
  output logic                     enable_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [1:0]               state_o
);

  localparam int c_AW = $clog2(DEPTH);

  localparam logic [c_AW:0] c_LVL_ZERO = '0;
  localparam logic [c_AW:0] c_LVL_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW:0] c_LVL_FULL = (c_AW+1)'(DEPTH);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_STREAM = 2'd1;
  localparam logic [1:0] c_ST_HOLD   = 2'd2;

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write/read counts carry one bit beyond the pointer so that the
  // difference distinguishes full from empty.
  logic [c_AW:0]    r_wr_cnt;
  logic [c_AW:0]    r_rd_cnt;
  logic             r_ready_en;
  logic             r_enable;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_state;

  logic [c_AW:0]    w_level;
  logic             w_push;
  logic             w_pop;
  logic             w_drain;
  logic [1:0]       w_state_next;

  assign w_level = r_wr_cnt - r_rd_cnt;

  // r_ready_en keeps s_ready_o low during reset and rises on the first edge
  // after release; otherwise ready depends only on the stored level.
  assign s_ready_o = r_ready_en & (w_level != c_LVL_FULL);

  assign w_push = s_valid_i & s_ready_o & ~clear_i;
  // Pop looks at the level before this edge, so a word pushed into an empty
  // FIFO cannot be popped on the same edge.
  assign w_pop  = (w_level != c_LVL_ZERO) & ~stall_i & ~clear_i;

  // Level becomes zero at this edge without a new word arriving.
  assign w_drain = ~w_push &
                   ((w_level == c_LVL_ZERO) | ((w_level == c_LVL_ONE) & w_pop));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (clear_i) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (w_push) r_wr_cnt <= r_wr_cnt + c_LVL_ONE;
        if (w_pop)  r_rd_cnt <= r_rd_cnt + c_LVL_ONE;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_cnt[c_AW-1:0]] <= s_data_i;
  end

  // data_o holds across stalls and flushes, so a word is never re-strobed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_enable <= 1'b0;
      r_data   <= '0;
    end else begin
      r_enable <= w_pop;
      if (w_pop) r_data <= r_mem[r_rd_cnt[c_AW-1:0]];
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_push) w_state_next = c_ST_STREAM;
        end
        c_ST_STREAM: begin
          if (stall_i && (w_level != c_LVL_ZERO)) w_state_next = c_ST_HOLD;
          else if (w_drain)                       w_state_next = c_ST_IDLE;
        end
        c_ST_HOLD: begin
          // Nothing pops while in HOLD, so the level stays non-zero unless
          // flushed; the IDLE fallback only guards an unexpected empty FIFO.
          if (!stall_i) begin
            w_state_next = (w_level != c_LVL_ZERO) ? c_ST_STREAM : c_ST_IDLE;
          end
        end
        default: w_state_next = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= c_ST_IDLE;
    else         r_state <= w_state_next;
  end

  assign enable_o = r_enable;
  assign data_o   = r_data;
  assign level_o  = w_level;
  assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stream_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_feeder
// Description : Self-checking bench for stream_feeder. An 8-bit instance is
//               exercised with directed scenarios; a 32-bit instance runs in
//               lockstep on the same controls and joins the random scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_feeder;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        s_valid_i;
  logic        stall_i;
  logic [7:0]  s_data_i;
  logic [31:0] s_data32;

  logic        s_ready8, en8;
  logic [7:0]  data8;
  logic [2:0]  level8;
  logic [1:0]  state8;
  logic        s_ready32, en32;
  logic [31:0] data32;
  logic [2:0]  level32;
  logic [1:0]  state32;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last8;

  always #5 clk_i = ~clk_i;

  stream_feeder #(.WIDTH(8), .DEPTH(DEPTH)) u_dut8 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready8), .s_data_i(s_data_i),
    .stall_i(stall_i), .enable_o(en8), .data_o(data8),
    .level_o(level8), .state_o(state8)
  );

  stream_feeder #(.WIDTH(32), .DEPTH(DEPTH)) u_dut32 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready32), .s_data_i(s_data32),
    .stall_i(stall_i), .enable_o(en32), .data_o(data32),
    .level_o(level32), .state_o(state32)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; s_valid_i = 1'b0; stall_i = 1'b0;
    s_data_i = 8'h00; s_data32 = 32'h0;
    repeat (3) step();
    n_checks++;
    if ({en8, data8, level8, state8} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b data=%h level=%0d state=%0d, expected all 0",
               en8, data8, level8, state8);
    end
    n_checks++;
    if (s_ready8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0", s_ready8);
    end
    rst_ni = 1'b1;
    #2;
    n_checks++;
    if (s_ready8 !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", s_ready8);
    end
    step();
    n_checks++;
    if (s_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_edge: got %b expected 1", s_ready8);
    end
  endtask

  task automatic test_single_word();
    s_valid_i = 1'b1; s_data_i = 8'hA5;
    step();
    s_valid_i = 1'b0;
    n_checks++;
    if ({en8, level8, state8} !== {1'b0, 3'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL single_push: got en=%b level=%0d state=%0d expected en=0 level=1 state=1",
               en8, level8, state8);
    end
    step();
    n_checks++;
    if ({en8, data8, level8, state8} !== {1'b1, 8'hA5, 3'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL single_strobe: got en=%b data=%h level=%0d state=%0d expected 1 a5 0 0",
               en8, data8, level8, state8);
    end
    step();
    n_checks++;
    if ({en8, data8} !== {1'b0, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_hold: got en=%b data=%h expected en=0 data=a5", en8, data8);
    end
  endtask

  task automatic test_stall_fill();
    logic [7:0] exp_data [5];
    logic [2:0] exp_lvl  [5];
    exp_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    exp_lvl  = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    stall_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(i);
      step();
      n_checks++;
      if (en8 !== 1'b0 || level8 !== 3'((i > DEPTH) ? DEPTH : i)) begin
        n_fail++;
        $display("FAIL fill_%0d: got en=%b level=%0d expected en=0 level=%0d",
                 i, en8, level8, (i > DEPTH) ? DEPTH : i);
      end
    end
    n_checks++;
    if ({s_ready8, state8} !== {1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL full_hold: got ready=%b state=%0d expected ready=0 state=2", s_ready8, state8);
    end
    stall_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) s_valid_i = 1'b0;
      n_checks++;
      if ({en8, data8, level8} !== {1'b1, exp_data[k], exp_lvl[k]}) begin
        n_fail++;
        $display("FAIL drain_%0d: got en=%b data=%h level=%0d expected en=1 data=%h level=%0d",
                 k, en8, data8, level8, exp_data[k], exp_lvl[k]);
      end
    end
    last8 = 8'h05;
    step();
    n_checks++;
    if ({en8, state8} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL drain_end: got en=%b state=%0d expected en=0 state=0", en8, state8);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    logic v, st, push, pop;
    logic [7:0] d;
    int pre;
    for (int i = 0; i < 30; i++) begin
      v  = (i < 24);
      st = (i < 4) || (i % 4 == 3);
      d  = 8'(8'h40 + i);
      s_valid_i = v; stall_i = st; s_data_i = d;
      pre  = q.size();
      push = v && (pre != DEPTH);
      pop  = (pre > 0) && !st;
      if (pop)  last8 = q.pop_front();
      if (push) q.push_back(d);
      step();
      n_checks++;
      if (en8 !== pop || data8 !== last8 || level8 !== 3'(q.size()) ||
          s_ready8 !== (q.size() != DEPTH)) begin
        n_fail++;
        $display("FAIL wrap_%0d: got en=%b data=%h level=%0d ready=%b expected en=%b data=%h level=%0d ready=%b",
                 i, en8, data8, level8, s_ready8, pop, last8, q.size(), q.size() != DEPTH);
      end
    end
    s_valid_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_clear();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(8'hC1 + i);
      step();
    end
    n_checks++;
    if (level8 !== 3'd3) begin
      n_fail++; $display("FAIL clear_setup: got level=%0d expected 3", level8);
    end
    s_data_i = 8'hC4; clear_i = 1'b1; stall_i = 1'b0;
    step();
    clear_i = 1'b0; s_valid_i = 1'b0;
    n_checks++;
    if ({en8, data8, level8, state8, s_ready8} !== {1'b0, last8, 3'd0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_edge: got en=%b data=%h level=%0d state=%0d ready=%b expected 0 %h 0 0 1",
               en8, data8, level8, state8, s_ready8, last8);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({en8, level8} !== {1'b0, 3'd0}) begin
        n_fail++;
        $display("FAIL clear_after_%0d: got en=%b level=%0d expected en=0 level=0", i, en8, level8);
      end
    end
  endtask

  task automatic test_async_reset();
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(8'h71 + i);
      step();
    end
    s_valid_i = 1'b0;
    n_checks++;
    if (level8 !== 3'd2) begin
      n_fail++; $display("FAIL areset_setup: got level=%0d expected 2", level8);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({en8, data8, level8, state8, s_ready8} !== 15'h0) begin
      n_fail++;
      $display("FAIL areset_now: got en=%b data=%h level=%0d state=%0d ready=%b expected all 0",
               en8, data8, level8, state8, s_ready8);
    end
    #2 rst_ni = 1'b1;
    stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({en8, level8} !== {1'b0, 3'd0}) begin
        n_fail++;
        $display("FAIL areset_quiet_%0d: got en=%b level=%0d expected en=0 level=0", i, en8, level8);
      end
    end
    s_valid_i = 1'b1; s_data_i = 8'h3C;
    step();
    s_valid_i = 1'b0;
    step();
    n_checks++;
    if ({en8, data8} !== {1'b1, 8'h3C}) begin
      n_fail++;
      $display("FAIL areset_resume: got en=%b data=%h expected en=1 data=3c", en8, data8);
    end
  endtask

  task automatic test_random();
    logic [7:0]  q8  [$];
    logic [31:0] q32 [$];
    logic [31:0] last32;
    logic v, st, push, pop;
    logic [31:0] d32;
    int pre;
    rst_ni = 1'b0; s_valid_i = 1'b0; stall_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    last8 = 8'h00; last32 = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 3) == 0);
      d32 = $urandom;
      s_valid_i = v; stall_i = st; s_data32 = d32; s_data_i = d32[15:8];
      pre  = q8.size();
      push = v && (pre != DEPTH);
      pop  = (pre > 0) && !st;
      if (pop) begin
        last8  = q8.pop_front();
        last32 = q32.pop_front();
      end
      if (push) begin
        q8.push_back(d32[15:8]);
        q32.push_back(d32);
      end
      step();
      n_checks++;
      if (en8 !== pop || data8 !== last8 || level8 !== 3'(q8.size())) begin
        n_fail++;
        $display("FAIL rand8_%0d: got en=%b data=%h level=%0d expected en=%b data=%h level=%0d",
                 i, en8, data8, level8, pop, last8, q8.size());
      end
      n_checks++;
      if (en32 !== pop || data32 !== last32 || level32 !== 3'(q32.size())) begin
        n_fail++;
        $display("FAIL rand32_%0d: got en=%b data=%h level=%0d expected en=%b data=%h level=%0d",
                 i, en32, data32, level32, pop, last32, q32.size());
      end
    end
    s_valid_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stall_fill();
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
